// File: rtl/dds_pkg.sv
// Shared definitions for the AD9850-class DDS serial loader: word layout,
// bit-counter limits and the loader FSM state encoding.
// The ENTRY states are only reachable when DDS_SERIAL_ENTRY_EN is defined.
package dds_pkg;

    localparam int DDS_WORD_BITS = 40;

    // Field offsets inside the 40-bit serial word (bit 0 is shifted first)
    localparam int FREQ_LSB  = 0;
    localparam int CTRL_LSB  = 32;
    localparam int PD_BIT    = 34;
    localparam int PHASE_LSB = 35;

    localparam int         BIT_CNT_W = 6;
    localparam logic [5:0] LAST_BIT  = 6'd39;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY_LO = 3'd1,
        ST_ENTRY_HI = 3'd2,
        ST_ENTRY_FQ = 3'd3,
        ST_SHIFT_LO = 3'd4,
        ST_SHIFT_HI = 3'd5,
        ST_FQ_HI    = 3'd6
    } loader_state_e;

    // Assemble the serial word: {phase, power_down, control = 2'b00, freq}
    function automatic logic [DDS_WORD_BITS-1:0] build_word(
        input logic [31:0] freq,
        input logic [4:0]  ph,
        input logic        pd
    );
        logic [DDS_WORD_BITS-1:0] w;
        w                  = '0;
        w[FREQ_LSB +: 32]  = freq;
        w[CTRL_LSB +: 2]   = 2'b00;
        w[PD_BIT]          = pd;
        w[PHASE_LSB +: 5]  = ph;
        return w;
    endfunction

endpackage

// File: rtl/dds_tick_gen.sv
// Free-running period counter for the DDS loader. Emits a one-cycle tick
// every (limit_i + 1) cycles; restart_i holds the count at zero so the
// first tick after release arrives exactly limit_i + 1 cycles later.
module dds_tick_gen #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the terminal count, then wrap so back-to-back periods are seamless
    always_comb begin
        tick_o = !restart_i && (cnt_q == limit_i);
        cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_serial_loader.sv
// Serial word loader for the AD9850-class DDS. Latches a frequency/phase
// request, shifts the 40-bit word LSB-first on dds_data/dds_wclk, then pulses
// fq_ud to commit it. All outputs are registered.
// Optional: DDS_SERIAL_ENTRY_EN adds a one-time serial-mode entry sequence
// (one wclk pulse then one fq_ud pulse) before the first load after reset.
module dds_serial_loader
    import dds_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int FQ_PULSE    = 4
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] freq_word,
    input  logic [4:0]  phase,
    input  logic        power_down,
    output logic        busy,
    output logic        done,
    output logic        dds_data,
    output logic        dds_wclk,
    output logic        fq_ud
);

    localparam int MAX_PERIOD = (HALF_PERIOD > FQ_PULSE) ? HALF_PERIOD : FQ_PULSE;
    localparam int CNT_W      = $clog2(MAX_PERIOD + 1);
    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] F_LIM = CNT_W'(FQ_PULSE - 1);

    loader_state_e            state_q, state_d;
    logic [DDS_WORD_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]     bit_q, bit_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     data_q, data_d;
    logic                     wclk_q, wclk_d;
    logic                     fq_q, fq_d;
`ifdef DDS_SERIAL_ENTRY_EN
    logic                     entry_done_q, entry_done_d;
`endif

    logic [DDS_WORD_BITS-1:0] load_word;
    logic                     tick_restart;
    logic [CNT_W-1:0]         tick_limit;
    logic                     tick;

    assign load_word = build_word(freq_word, phase, power_down);

    dds_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk_i     (clk_100M),
        .rst_i     (rst),
        .restart_i (tick_restart),
        .limit_i   (tick_limit),
        .tick_o    (tick)
    );

    // Timer control: held in IDLE, fq_ud pulse width while strobing, wclk half-period otherwise
    always_comb begin
        tick_restart = (state_q == ST_IDLE);
        tick_limit   = H_LIM;
        if (state_q == ST_FQ_HI || state_q == ST_ENTRY_FQ) begin
            tick_limit = F_LIM;
        end
    end

    // Next-state and next-output logic; every transition happens on a timer tick
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
        wclk_d  = wclk_q;
        fq_d    = fq_q;
`ifdef DDS_SERIAL_ENTRY_EN
        entry_done_d = entry_done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = load_word;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    wclk_d  = 1'b0;
                    fq_d    = 1'b0;
`ifdef DDS_SERIAL_ENTRY_EN
                    if (!entry_done_q) begin
                        entry_done_d = 1'b1;
                        data_d       = 1'b0;
                        state_d      = ST_ENTRY_LO;
                    end else begin
                        data_d  = load_word[0];
                        state_d = ST_SHIFT_LO;
                    end
`else
                    data_d  = load_word[0];
                    state_d = ST_SHIFT_LO;
`endif
                end
            end
`ifdef DDS_SERIAL_ENTRY_EN
            ST_ENTRY_LO: begin
                if (tick) begin
                    wclk_d  = 1'b1;
                    state_d = ST_ENTRY_HI;
                end
            end
            ST_ENTRY_HI: begin
                if (tick) begin
                    wclk_d  = 1'b0;
                    fq_d    = 1'b1;
                    state_d = ST_ENTRY_FQ;
                end
            end
            ST_ENTRY_FQ: begin
                if (tick) begin
                    fq_d    = 1'b0;
                    data_d  = shift_q[0];
                    state_d = ST_SHIFT_LO;
                end
            end
`endif
            ST_SHIFT_LO: begin
                if (tick) begin
                    wclk_d  = 1'b1;
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    wclk_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        fq_d    = 1'b1;
                        data_d  = 1'b0;
                        state_d = ST_FQ_HI;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[DDS_WORD_BITS-1:1]};
                        data_d  = shift_q[1];
                        state_d = ST_SHIFT_LO;
                    end
                end
            end
            ST_FQ_HI: begin
                if (tick) begin
                    fq_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                data_d  = 1'b0;
                wclk_d  = 1'b0;
                fq_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any load immediately
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 1'b0;
            wclk_q  <= 1'b0;
            fq_q    <= 1'b0;
`ifdef DDS_SERIAL_ENTRY_EN
            entry_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            wclk_q  <= wclk_d;
            fq_q    <= fq_d;
`ifdef DDS_SERIAL_ENTRY_EN
            entry_done_q <= entry_done_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dds_data = data_q;
    assign dds_wclk = wclk_q;
    assign fq_ud    = fq_q;

endmodule

// File: tb/tb_dds_serial_loader.sv
// Scoreboard bench for dds_serial_loader. Two instances: default timing
// (HALF_PERIOD=4) and fast timing (HALF_PERIOD=1). Expected words and done
// cycles are queued when a start is driven and checked when the DUT commits.
// Honours DDS_SERIAL_ENTRY_EN for the first-load entry sequence.
module tb_dds_serial_loader;

    localparam int H1 = 4;
    localparam int H2 = 1;
    localparam int FQ = 4;

    typedef struct {
        logic [39:0] word;
        int          doneCyc;
    } sbItem_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [31:0] freq_word = '0;
    logic [4:0]  phase = '0;
    logic        power_down = 1'b0;
    logic        busy, done, dds_data, dds_wclk, fq_ud;

    logic        start2 = 1'b0;
    logic [31:0] freq2 = '0;
    logic [4:0]  phase2 = '0;
    logic        pd2 = 1'b0;
    logic        busy2, done2, data2, wclk2, fq2;

    int          assertCount = 0;
    int          failCount = 0;
    int          cyc = 0;
    bit          entryPend1 = 1'b0;
    bit          entryPend2 = 1'b0;
    sbItem_t     sbq1[$];
    sbItem_t     sbq2[$];

    dds_serial_loader #(.HALF_PERIOD(H1), .FQ_PULSE(FQ)) u_dut (
        .clk_100M   (clk),
        .rst        (rst),
        .start      (start),
        .freq_word  (freq_word),
        .phase      (phase),
        .power_down (power_down),
        .busy       (busy),
        .done       (done),
        .dds_data   (dds_data),
        .dds_wclk   (dds_wclk),
        .fq_ud      (fq_ud)
    );

    dds_serial_loader #(.HALF_PERIOD(H2), .FQ_PULSE(FQ)) u_dut_fast (
        .clk_100M   (clk),
        .rst        (rst),
        .start      (start2),
        .freq_word  (freq2),
        .phase      (phase2),
        .power_down (pd2),
        .busy       (busy2),
        .done       (done2),
        .dds_data   (data2),
        .dds_wclk   (wclk2),
        .fq_ud      (fq2)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Cycle index; stable when sampled on the falling edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Hard stop if the bench ever stalls
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int latency(input int h, input bit entry);
        return 1 + 80 * h + FQ + (entry ? (2 * h + FQ) : 0);
    endfunction

    // Drive one start at the current falling edge; queue the expectation if it should be accepted
    task automatic applyStimulus(input int inst, input logic [31:0] f, input logic [4:0] ph,
                                 input logic pd, input bit accept);
        sbItem_t it;
        bit      useEntry;
        useEntry = 1'b0;
        it.word  = {ph, pd, 2'b00, f};
        if (inst == 1) begin
            freq_word = f; phase = ph; power_down = pd; start = 1'b1;
            if (accept) begin
`ifdef DDS_SERIAL_ENTRY_EN
                useEntry   = entryPend1;
                entryPend1 = 1'b0;
`endif
                it.doneCyc = cyc + latency(H1, useEntry);
                sbq1.push_back(it);
            end
        end else begin
            freq2 = f; phase2 = ph; pd2 = pd; start2 = 1'b1;
            if (accept) begin
`ifdef DDS_SERIAL_ENTRY_EN
                useEntry   = entryPend2;
                entryPend2 = 1'b0;
`endif
                it.doneCyc = cyc + latency(H2, useEntry);
                sbq2.push_back(it);
            end
        end
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
        checkOutput("busyAfterStart", (inst == 1) ? busy : busy2, 1);
    endtask

    // Wait (bounded) for done of one instance; returns on the falling edge of the done cycle
    task automatic waitDone(input int inst, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((inst == 1 && done) || (inst == 2 && done2)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("doneTimeout", 0, 1);
    endtask

    // Monitor for the default-timing instance: collects bits, checks hold, strobe and done timing
    initial begin
        int          bitCnt;
        int          fqLen;
        logic        wPrev, fqPrev, dataPrev, riseData;
        logic [39:0] colWord, capWord;
        sbItem_t     it;
        bitCnt = 0; fqLen = 0; wPrev = 0; fqPrev = 0; dataPrev = 0; riseData = 0;
        colWord = '0; capWord = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bitCnt = 0; fqLen = 0; wPrev = 0; fqPrev = 0; dataPrev = 0;
                colWord = '0; capWord = '0;
            end else begin
                if (!wPrev && dds_wclk) begin
                    if (bitCnt < 40) colWord[bitCnt] = dds_data;
                    riseData = dds_data;
                    bitCnt++;
                end
                if (wPrev && !dds_wclk) checkOutput("dataHold", dataPrev, riseData);
                if (!fqPrev && fq_ud) begin
                    checkOutput("fqData", dds_data, 0);
                    if (bitCnt == 40) begin
                        capWord = colWord;
                        if (sbq1.size() > 0) checkOutput("fqRiseCyc", cyc, sbq1[0].doneCyc - FQ);
                        else checkOutput("unexpectedFq", 1, 0);
                    end else begin
`ifdef DDS_SERIAL_ENTRY_EN
                        checkOutput("entryBits", bitCnt, 1);
`else
                        checkOutput("bitCount", bitCnt, 40);
`endif
                    end
                    bitCnt  = 0;
                    fqLen   = 0;
                    colWord = '0;
                end
                if (fq_ud) fqLen++;
                if (fqPrev && !fq_ud) checkOutput("fqWidth", fqLen, FQ);
                if (done) begin
                    if (sbq1.size() == 0) begin
                        checkOutput("unexpectedDone", 1, 0);
                    end else begin
                        it = sbq1.pop_front();
                        checkOutput("doneCyc", cyc, it.doneCyc);
                        checkOutput("word", capWord, it.word);
                        checkOutput("busyAtDone", busy, 0);
                    end
                    capWord = '0;
                end
                wPrev    = dds_wclk;
                fqPrev   = fq_ud;
                dataPrev = dds_data;
            end
        end
    end

    // Monitor for the fast instance: collects bits and checks word and done timing
    initial begin
        int          bitCnt;
        logic        wPrev, fqPrev;
        logic [39:0] colWord, capWord;
        sbItem_t     it;
        bitCnt = 0; wPrev = 0; fqPrev = 0; colWord = '0; capWord = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bitCnt = 0; wPrev = 0; fqPrev = 0; colWord = '0; capWord = '0;
            end else begin
                if (!wPrev && wclk2) begin
                    if (bitCnt < 40) colWord[bitCnt] = data2;
                    bitCnt++;
                end
                if (!fqPrev && fq2) begin
                    if (bitCnt == 40) capWord = colWord;
                    bitCnt  = 0;
                    colWord = '0;
                end
                if (done2) begin
                    if (sbq2.size() == 0) begin
                        checkOutput("fastUnexpectedDone", 1, 0);
                    end else begin
                        it = sbq2.pop_front();
                        checkOutput("fastDoneCyc", cyc, it.doneCyc);
                        checkOutput("fastWord", capWord, it.word);
                    end
                    capWord = '0;
                end
                wPrev  = wclk2;
                fqPrev = fq2;
            end
        end
    end

    // Main sequence
    initial begin
        logic anyHigh;
        $display("[TB] dds_serial_loader bench starting");
        rst = 1'b1;
        entryPend1 = 1'b1;
        entryPend2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstData", dds_data, 0);
        checkOutput("rstWclk", dds_wclk, 0);
        checkOutput("rstFq", fq_ud, 0);

        anyHigh = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            anyHigh = anyHigh | busy | done | dds_data | dds_wclk | fq_ud
                              | busy2 | done2 | data2 | wclk2 | fq2;
        end
        checkOutput("idleQuiet", anyHigh, 0);

        applyStimulus(1, 32'h0A3D70A4, 5'h00, 1'b0, 1'b1);
        waitDone(1, 400);
        @(negedge clk);

        applyStimulus(1, 32'h0000_0000, 5'h15, 1'b1, 1'b1);
        waitDone(1, 400);
        @(negedge clk);

        applyStimulus(1, 32'hDEAD_BEEF, 5'h0C, 1'b0, 1'b1);
        repeat (99) @(negedge clk);
        applyStimulus(1, 32'h1234_5678, 5'h1F, 1'b1, 1'b0);
        waitDone(1, 400);
        applyStimulus(1, 32'hFFFF_FFFF, 5'h1F, 1'b1, 1'b1);
        waitDone(1, 400);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
            waitDone(1, 400);
            @(negedge clk);
        end

        applyStimulus(1, 32'h5555_AAAA, 5'h0A, 1'b1, 1'b1);
        repeat (149) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortData", dds_data, 0);
        checkOutput("abortWclk", dds_wclk, 0);
        checkOutput("abortFq", fq_ud, 0);
        sbq1.delete();
        sbq2.delete();
        entryPend1 = 1'b1;
        entryPend2 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        anyHigh = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            anyHigh = anyHigh | fq_ud | done | busy;
        end
        checkOutput("abortNoFq", anyHigh, 0);

        applyStimulus(2, 32'hC0FF_EE01, 5'h13, 1'b0, 1'b1);
        waitDone(2, 200);
        @(negedge clk);
        applyStimulus(2, 32'h8000_0001, 5'h01, 1'b1, 1'b1);
        waitDone(2, 200);

        repeat (10) @(negedge clk);
        checkOutput("sbEmpty1", sbq1.size(), 0);
        checkOutput("sbEmpty2", sbq2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
